// File: rtl/nes_joypad_poller.sv
// nes_joypad_poller: polls an NES pad over latch/clock/data and publishes its buttons and presence.
module nes_joypad_poller #(
  parameter int C_latch_cycles = 258,
  parameter int C_half_cycles  = 129,
  parameter int C_poll_cycles  = 357955,
  parameter int C_sync_stages  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       poll_now,
  input  logic       joy_data,
  output logic       joy_latch,
  output logic       joy_clock,
  output logic [7:0] buttons,
  output logic       present,
  output logic       valid,
  output logic       busy
);
  localparam int TW = $clog2(C_poll_cycles);
  localparam int PW = $clog2(C_latch_cycles > C_half_cycles ? C_latch_cycles : C_half_cycles);
  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_CLK_LO, S_CLK_HI, S_DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer;
  logic [PW-1:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic [8:0] raw;
  logic [C_sync_stages-1:0] sync;
  logic pending, wrap, last, start, sample, clk_fall, clk_rise;
  always_comb begin
    wrap = timer == TW'(C_poll_cycles - 1);
    last = cnt == PW'((state == S_LATCH ? C_latch_cycles : C_half_cycles) - 1);
    start = state == S_IDLE && pending;
    sample = last && (state == S_LATCH || state == S_CLK_HI);
    // joy_clock edges lead the phase boundaries by one cycle so the synchronizer delay fits inside each sampled phase
    clk_fall = (state == S_LATCH && cnt == PW'(C_latch_cycles - 2)) ||
               (state == S_CLK_HI && cnt == PW'(C_half_cycles - 2) && idx != 4'd8);
    clk_rise = state == S_CLK_LO && cnt == PW'(C_half_cycles - 2);
    state_n = state;
    cnt_n = last ? '0 : cnt + 1'b1;
    idx_n = idx;
    case (state)
      S_IDLE: begin
        state_n = pending ? S_LATCH : S_IDLE;
        cnt_n = '0;
        idx_n = '0;
      end
      S_LATCH: state_n = last ? S_CLK_LO : S_LATCH;
      S_CLK_LO: begin
        state_n = last ? S_CLK_HI : S_CLK_LO;
        idx_n = last ? idx + 1'b1 : idx;
      end
      S_CLK_HI: state_n = !last ? S_CLK_HI : idx == 4'd8 ? S_DONE : S_CLK_LO;
      S_DONE: begin
        state_n = S_IDLE;
        cnt_n = '0;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      timer <= '0;
      pending <= 1'b0;
      cnt <= '0;
      idx <= '0;
      raw <= '1;
      sync <= '1;
      joy_latch <= 1'b0;
      joy_clock <= 1'b1;
      buttons <= '0;
      present <= 1'b0;
      valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      timer <= wrap ? '0 : timer + 1'b1;
      pending <= poll_now || wrap || (pending && !start);
      sync <= {sync[C_sync_stages-2:0], joy_data};
      if (sample) raw[idx] <= sync[C_sync_stages-1];
      joy_latch <= state_n == S_LATCH;
      joy_clock <= clk_fall ? 1'b0 : clk_rise ? 1'b1 : joy_clock;
      busy <= state_n inside {S_LATCH, S_CLK_LO, S_CLK_HI};
      valid <= state == S_DONE;
      if (state == S_DONE) begin
        buttons <= ~raw[7:0];
        present <= ~raw[8];
      end
    end
  end
endmodule

// File: tb/tb_nes_joypad_poller.sv
// tb_nes_joypad_poller: pad model plus transaction-level scoreboard for the joypad poller.
module tb_nes_joypad_poller;
  localparam int L = 4, H = 2, P = 100, S = 2;
  localparam int FRAME = 1 + L + 16 * H + 1;
  logic clk = 1'b0, reset_n = 1'b0, poll_now = 1'b0, joy_data;
  logic joy_latch, joy_clock, present, valid, busy;
  logic [7:0] buttons;
  nes_joypad_poller #(.C_latch_cycles(L), .C_half_cycles(H), .C_poll_cycles(P), .C_sync_stages(S)) dut (
    .clk(clk), .reset_n(reset_n), .poll_now(poll_now), .joy_data(joy_data),
    .joy_latch(joy_latch), .joy_clock(joy_clock), .buttons(buttons),
    .present(present), .valid(valid), .busy(busy)
  );
  always #5 clk = ~clk;
  // 4021-style pad: parallel load while latched, shift on joy_clock rise, 9th bit low
  logic pad_on = 1'b0;
  logic [7:0] pad_btn = 8'h00;
  logic [8:0] pad_sr = '1;
  assign joy_data = pad_on ? pad_sr[0] : 1'b1;
  always @(posedge joy_clock or posedge joy_latch)
    pad_sr <= joy_latch ? {1'b0, ~pad_btn} : {1'b1, pad_sr[8:1]};
  typedef struct { int at; logic [7:0] btn; logic pres; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int cyc = 0, m_k = 0, m_free = 0, m_busy_end = 0;
  int lat_run = 0, lo_run = 0, falls = 0;
  logic m_pend = 1'b0, m_pres = 1'b0, prev_latch = 1'b0, prev_clk = 1'b1;
  logic [7:0] m_btn = 8'h00;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  always @(posedge clk) begin
    logic rst, start;
    cyc++;
    rst = !reset_n;
    start = 1'b0;
    if (rst) begin
      q.delete();
      m_pend = 1'b0;
      m_k = 0;
      m_free = 0;
      m_busy_end = 0;
      m_btn = 8'h00;
      m_pres = 1'b0;
    end else begin
      start = m_pend && cyc >= m_free;
      if (start) begin
        q.push_back('{cyc + FRAME - 1, pad_on ? pad_btn : 8'h00, pad_on});
        m_free = cyc + FRAME;
        m_busy_end = cyc + FRAME - 2;
      end
      m_pend = poll_now || (m_k % P == P - 1) || (m_pend && !start);
      m_k++;
    end
    #1;
    if (rst) begin
      check("rst_latch", joy_latch, 0);
      check("rst_clock", joy_clock, 1);
      check("rst_buttons", buttons, 0);
      check("rst_present", present, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      lat_run = 0;
      lo_run = 0;
      falls = 0;
    end else begin
      if (q.size() > 0 && q[0].at == cyc) begin
        check("valid", valid, 1);
        check("clock_pulses", falls, 8);
        m_btn = q[0].btn;
        m_pres = q[0].pres;
        falls = 0;
        void'(q.pop_front());
      end else check("no_valid", valid, 0);
      check("buttons", buttons, m_btn);
      check("present", present, m_pres);
      check("busy", busy, cyc < m_busy_end);
      if (prev_latch && !joy_latch) check("latch_width", lat_run, L);
      if (!prev_clk && joy_clock) check("low_width", lo_run, H);
      if (prev_clk && !joy_clock) falls++;
      lat_run = joy_latch ? lat_run + 1 : 0;
      lo_run = joy_clock ? 0 : lo_run + 1;
    end
    prev_latch = joy_latch;
    prev_clk = joy_clock;
  end
  task automatic poll();
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
  endtask
  task automatic wait_quiet();
    int n = 0;
    @(negedge clk);
    while ((busy || m_pend || q.size() > 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      $display("FAIL wait_quiet: poller still busy after %0d cycles", n);
      $fatal(1, "timeout");
    end
  endtask
  initial begin
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    pad_on = 1'b1;
    pad_btn = 8'h89;
    repeat (3) @(negedge clk);
    poll();
    wait_quiet();
    pad_on = 1'b0;
    while (m_k < P + 1) @(negedge clk);
    wait_quiet();
    pad_on = 1'b1;
    pad_btn = 8'($urandom);
    poll();
    repeat (10) @(negedge clk);
    poll_now = 1'b1;
    repeat (3) @(negedge clk);
    poll_now = 1'b0;
    wait_quiet();
    repeat (P) @(negedge clk);
    wait_quiet();
    for (int n = 0; n < 3 * P && !(m_k % P == P - 1 && !busy && !m_pend && q.size() == 0); n++)
      @(negedge clk);
    poll();
    wait_quiet();
    pad_btn = 8'($urandom);
    poll();
    repeat (13) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    poll();
    wait_quiet();
    pad_btn = 8'h01;
    poll();
    wait_quiet();
    pad_btn = 8'hF0;
    poll();
    wait_quiet();
    for (int i = 0; i < 8; i++) begin
      pad_on = $urandom_range(0, 3) != 0;
      pad_btn = 8'($urandom);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      poll();
      wait_quiet();
    end
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
